// File: rtl/cgra_tx_serializer_pkg.sv
// Shared SoC constants and types for the CGRA TX serializer slice.
// Instance defaults for packet width, AXI beat width and buffer depth live here.
package cgra_tx_serializer_pkg;

  localparam int AXI_DATA_W    = 64;
  localparam int CGRA_PKT_W    = 192;
  localparam int BEATS_PER_PKT = CGRA_PKT_W / AXI_DATA_W;
  localparam int TX_DEPTH      = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/cgra_tx_serializer_if.sv
// AXI-Stream style bundle: wide packet input from the CGRA bridge and the
// beat output towards the DMA TX datapath.
interface cgra_tx_serializer_if
  import cgra_tx_serializer_pkg::*;
#(
  parameter int AXIS_W = CGRA_PKT_W,
  parameter int BEAT_W = AXI_DATA_W
);

  logic [AXIS_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [BEAT_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/cgra_tx_serializer_pkt_fifo.sv
// Whole-packet synchronous FIFO (cgra_tx_pkt_fifo) with flush, exposing both
// the head entry and the one behind it so the serializer can chain packets.
module cgra_tx_pkt_fifo
  import cgra_tx_serializer_pkg::*;
#(
  parameter  int WIDTH = CGRA_PKT_W,
  parameter  int DEPTH = TX_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [WIDTH-1:0] next_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cgra_tx_pkt_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    rd_next;
  logic [CW-1:0]    count_q;

  // Pointers are exactly log2(DEPTH) wide, so increments wrap on their own.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign rd_next     = rd_ptr_q + 1'b1;
  assign head_data_o = mem_q[rd_ptr_q];
  assign next_data_o = mem_q[rd_next];
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;

endmodule

// File: rtl/cgra_tx_serializer.sv
// Splits buffered CGRA packets into LSB-first AXI beats with tlast on the final beat.
// Define CGRA_TX_SER_CNT_EN to build the emitted-packet counter on pkt_cnt.
module cgra_tx_serializer
  import cgra_tx_serializer_pkg::*;
#(
  parameter  int AXIS_W  = CGRA_PKT_W,
  parameter  int BEAT_W  = AXI_DATA_W,
  parameter  int DEPTH   = TX_DEPTH,
  localparam int N_BEATS = AXIS_W / BEAT_W,
  localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rstn,
  cgra_tx_serializer_if.slave bus,
  input  logic                flush,
  output logic                busy,
  output logic [LW-1:0]       level,
  output logic [31:0]         pkt_cnt
);

  if (AXIS_W % BEAT_W != 0) begin : g_bad_width
    $error("cgra_tx_serializer: AXIS_W must be a multiple of BEAT_W");
  end

  localparam logic [BW-1:0] LAST_BEAT = BW'(N_BEATS - 1);

  ser_state_e        state_q;
  logic [BW-1:0]     beat_q;
  logic [BW-1:0]     beat_d;
  logic              tvalid_q;
  logic              tlast_q;
  logic [BEAT_W-1:0] tdata_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [LW-1:0]     fifo_count;
  logic [AXIS_W-1:0] head_pkt;
  logic [AXIS_W-1:0] next_pkt;
  logic [AXIS_W-1:0] src_pkt;
  logic              push;
  logic              out_hs;
  logic              last_hs;
  logic              more_pkts;

  assign push    = bus.s_axis_tvalid && !fifo_full;
  assign out_hs  = tvalid_q && bus.m_axis_tready;
  assign last_hs = out_hs && tlast_q;

  cgra_tx_pkt_fifo #(
    .WIDTH (AXIS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .push_i      (push),
    .push_data_i (bus.s_axis_tdata),
    .pop_i       (last_hs),
    .flush_i     (flush),
    .head_data_o (head_pkt),
    .next_data_o (next_pkt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // On the tlast beat the next packet is either the second FIFO entry or,
  // when only the head remains, the packet being pushed this very cycle.
  always_comb begin
    beat_d    = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    more_pkts = (fifo_count > LW'(1)) || push;
    src_pkt   = head_pkt;
    if (tlast_q) src_pkt = (fifo_count > LW'(1)) ? next_pkt : bus.s_axis_tdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else if (flush) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q  <= SEND;
            beat_q   <= '0;
            tvalid_q <= 1'b1;
            tdata_q  <= head_pkt[BEAT_W-1:0];
            tlast_q  <= (N_BEATS == 1);
          end
        end
        SEND: begin
          if (out_hs) begin
            if (!tlast_q || more_pkts) begin
              beat_q  <= beat_d;
              tdata_q <= src_pkt[int'(beat_d)*BEAT_W +: BEAT_W];
              tlast_q <= (beat_d == LAST_BEAT);
            end else begin
              state_q  <= IDLE;
              beat_q   <= '0;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CGRA_TX_SER_CNT_EN
  logic [31:0] pkt_cnt_q;

  // An aborted tlast handshake (flush in the same cycle) is not counted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt_q <= '0;
    end else if (last_hs && !flush) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = '0;
`endif

  assign bus.s_axis_tready = !fifo_full;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign level             = fifo_count;
  assign busy              = (fifo_count != '0) || (state_q == SEND);

endmodule

// File: tb/tb_cgra_tx_serializer.sv
// Directed self-checking bench for cgra_tx_serializer: single packet, back-to-back,
// output stall, flush, mid-packet reset and (with CGRA_TX_SER_CNT_EN) counter wrap.
module tb_cgra_tx_serializer;
  import cgra_tx_serializer_pkg::*;

`ifdef CGRA_TX_SER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        busy;
  logic [1:0]  level;
  logic [31:0] pkt_cnt;
  int          tests = 0;
  int          fails = 0;

  cgra_tx_serializer_if bus ();

  cgra_tx_serializer dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .flush   (flush),
    .busy    (busy),
    .level   (level),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [191:0] mkPkt(logic [63:0] b0, logic [63:0] b1, logic [63:0] b2);
    return {b2, b1, b0};
  endfunction

  // Beat k of back-to-back packet p carries (p+1)*0x100 + k + 1.
  function automatic logic [63:0] b2bBeat(int p, int k);
    return 64'((p + 1) * 256 + k + 1);
  endfunction

  function automatic logic [63:0] expCnt(int n);
    return CNT_EN ? 64'(n) : 64'd0;
  endfunction

  task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic [191:0] pkt);
    checkOutput("send_s_tready", 64'(bus.s_axis_tready), 64'd1);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = pkt;
    stepCycle();
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic checkReset(string tag);
    checkOutput({tag, "_s_tready"}, 64'(bus.s_axis_tready), 64'd1);
    checkOutput({tag, "_tvalid"},   64'(bus.m_axis_tvalid), 64'd0);
    checkOutput({tag, "_tlast"},    64'(bus.m_axis_tlast),  64'd0);
    checkOutput({tag, "_tdata"},    bus.m_axis_tdata,       64'd0);
    checkOutput({tag, "_busy"},     64'(busy),              64'd0);
    checkOutput({tag, "_level"},    64'(level),             64'd0);
    checkOutput({tag, "_pkt_cnt"},  64'(pkt_cnt),           64'd0);
  endtask

  initial begin
    bit          acc;
    bit          hs;
    logic [63:0] dat;
    logic        lst;
    int          sent;
    int          beats;
    int          lvl;
    int          first;
    int          last;

    rstn              = 1'b1;
    flush             = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checkReset("reset");
    stepCycle();
    stepCycle();
    rstn = 1'b1;
    stepCycle();

    // Single packet, beats 1,2,3
    bus.m_axis_tready = 1'b1;
    applyStimulus(mkPkt(64'd1, 64'd2, 64'd3));
    checkOutput("single_tvalid_at_accept", 64'(bus.m_axis_tvalid), 64'd0);
    checkOutput("single_level", 64'(level), 64'd1);
    stepCycle();
    checkOutput("single_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    checkOutput("single_beat0", bus.m_axis_tdata, 64'd1);
    checkOutput("single_tlast0", 64'(bus.m_axis_tlast), 64'd0);
    stepCycle();
    checkOutput("single_beat1", bus.m_axis_tdata, 64'd2);
    checkOutput("single_tlast1", 64'(bus.m_axis_tlast), 64'd0);
    stepCycle();
    checkOutput("single_beat2", bus.m_axis_tdata, 64'd3);
    checkOutput("single_tlast2", 64'(bus.m_axis_tlast), 64'd1);
    stepCycle();
    checkOutput("single_done_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    checkOutput("single_done_busy", 64'(busy), 64'd0);
    checkOutput("single_pkt_cnt", 64'(pkt_cnt), expCnt(1));

    // Four back-to-back packets
    sent  = 0;
    beats = 0;
    lvl   = 0;
    first = -1;
    last  = -1;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = mkPkt(b2bBeat(0, 0), b2bBeat(0, 1), b2bBeat(0, 2));
    for (int cyc = 0; cyc < 40 && beats < 12; cyc++) begin
      acc = bus.s_axis_tvalid && bus.s_axis_tready;
      hs  = bus.m_axis_tvalid && bus.m_axis_tready;
      dat = bus.m_axis_tdata;
      lst = bus.m_axis_tlast;
      stepCycle();
      if (hs) begin
        checkOutput("b2b_data", dat, b2bBeat(beats / BEATS_PER_PKT, beats % BEATS_PER_PKT));
        checkOutput("b2b_tlast", 64'(lst), 64'(beats % BEATS_PER_PKT == BEATS_PER_PKT - 1));
        if (first < 0) first = cyc;
        last = cyc;
        if (beats % BEATS_PER_PKT == BEATS_PER_PKT - 1) lvl--;
        beats++;
      end
      if (acc) begin
        lvl++;
        sent++;
        if (sent == 4) bus.s_axis_tvalid = 1'b0;
        else bus.s_axis_tdata = mkPkt(b2bBeat(sent, 0), b2bBeat(sent, 1), b2bBeat(sent, 2));
      end
      checkOutput("b2b_level", 64'(level), 64'(lvl));
      checkOutput("b2b_s_tready", 64'(bus.s_axis_tready), 64'(lvl != 2));
    end
    checkOutput("b2b_beat_count", 64'(beats), 64'd12);
    checkOutput("b2b_no_bubble_span", 64'(last - first), 64'd11);
    checkOutput("b2b_pkts_sent", 64'(sent), 64'd4);
    stepCycle();
    checkOutput("b2b_idle_busy", 64'(busy), 64'd0);
    checkOutput("b2b_pkt_cnt", 64'(pkt_cnt), expCnt(5));

    // Output stall in the middle of beat 1
    applyStimulus(mkPkt(64'h11, 64'h22, 64'h33));
    stepCycle();
    checkOutput("stall_beat0", bus.m_axis_tdata, 64'h11);
    stepCycle();
    checkOutput("stall_beat1", bus.m_axis_tdata, 64'h22);
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkOutput("stall_hold_data", bus.m_axis_tdata, 64'h22);
      checkOutput("stall_hold_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
      checkOutput("stall_hold_tlast", 64'(bus.m_axis_tlast), 64'd0);
    end
    bus.m_axis_tready = 1'b1;
    stepCycle();
    checkOutput("stall_beat2", bus.m_axis_tdata, 64'h33);
    checkOutput("stall_tlast2", 64'(bus.m_axis_tlast), 64'd1);
    stepCycle();
    checkOutput("stall_done_tvalid", 64'(bus.m_axis_tvalid), 64'd0);

    // Flush after beat 0 of A with B queued
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = mkPkt(64'hA0, 64'hA1, 64'hA2);
    stepCycle();
    bus.s_axis_tdata  = mkPkt(64'hB0, 64'hB1, 64'hB2);
    stepCycle();
    bus.s_axis_tvalid = 1'b0;
    checkOutput("flush_level_full", 64'(level), 64'd2);
    checkOutput("flush_a_beat0", bus.m_axis_tdata, 64'hA0);
    stepCycle();
    checkOutput("flush_a_beat1", bus.m_axis_tdata, 64'hA1);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    checkOutput("flush_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    checkOutput("flush_level", 64'(level), 64'd0);
    checkOutput("flush_busy", 64'(busy), 64'd0);
    stepCycle();
    checkOutput("flush_no_stray", 64'(bus.m_axis_tvalid), 64'd0);
    applyStimulus(mkPkt(64'hC0, 64'hC1, 64'hC2));
    stepCycle();
    checkOutput("flush_c_beat0", bus.m_axis_tdata, 64'hC0);
    checkOutput("flush_c_tlast0", 64'(bus.m_axis_tlast), 64'd0);
    stepCycle();
    checkOutput("flush_c_beat1", bus.m_axis_tdata, 64'hC1);
    stepCycle();
    checkOutput("flush_c_beat2", bus.m_axis_tdata, 64'hC2);
    checkOutput("flush_c_tlast2", 64'(bus.m_axis_tlast), 64'd1);
    stepCycle();
    checkOutput("flush_pkt_cnt", 64'(pkt_cnt), expCnt(7));

    // Reset asserted during beat 1
    applyStimulus(mkPkt(64'hD0, 64'hD1, 64'hD2));
    stepCycle();
    stepCycle();
    checkOutput("midrst_beat1", bus.m_axis_tdata, 64'hD1);
    #1 rstn = 1'b0;
    #1;
    checkReset("midrst");
    stepCycle();
    stepCycle();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("midrst_no_stray", 64'(bus.m_axis_tvalid), 64'd0);
    end
    checkOutput("midrst_level", 64'(level), 64'd0);

`ifdef CGRA_TX_SER_CNT_EN
    // Packet counter wraps from all-ones to zero
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt_q;
    #1;
    checkOutput("wrap_preload", 64'(pkt_cnt), 64'hFFFF_FFFF);
    stepCycle();
    applyStimulus(mkPkt(64'hE0, 64'hE1, 64'hE2));
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("wrap_tlast", 64'(bus.m_axis_tlast), 64'd1);
    stepCycle();
    checkOutput("wrap_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cgra_tx_serializer.md
CGRA_TX_SERIALIZER -- requirements
Module: cgra_tx_serializer

Interface
REQ-001 The block SHALL have parameter AXIS_W, default 192, giving the packet width in bits (zero-padded CGRA packet).
REQ-002 The block SHALL have parameter BEAT_W, default 64, giving the output beat width in bits (the AXI data width).
REQ-003 The block SHALL have parameter DEPTH, default 2, giving the number of whole packets buffered; it SHALL be a power of 2 and at least 2.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have the port rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have the ports s_axis_tdata (input, AXIS_W), s_axis_tvalid (input, 1) and s_axis_tready (output, 1): the packet input from the CGRA bridge.
REQ-007 The block SHALL have the ports m_axis_tdata (output, BEAT_W), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1): the beat output to the DMA TX write datapath.
REQ-008 The block SHALL have the port flush, input, 1 bit: synchronous abort and empty.
REQ-009 The block SHALL have the port busy, output, 1 bit: high while any packet is buffered or partially sent.
REQ-010 The block SHALL have the port level, output, $clog2(DEPTH)+1 bits: the number of whole or partial packets held.
REQ-011 The block SHALL have the port pkt_cnt, output, 32 bits: the count of packets fully emitted.

Function
REQ-012 BEATS_PER_PKT SHALL equal AXIS_W/BEAT_W; AXIS_W not being a multiple of BEAT_W SHALL be a elaboration-time $error.
REQ-013 s_axis_tready SHALL equal (level != DEPTH), with no combinational path from m_axis_tready.
REQ-014 A packet SHALL be accepted on a cycle where s_axis_tvalid and s_axis_tready are both high, and written to the FIFO tail.
REQ-015 Beat k of the head packet SHALL be s_axis_tdata[k*BEAT_W +: BEAT_W], for k = 0..BEATS_PER_PKT-1, emitted LSB-first.
REQ-016 m_axis_tlast SHALL be high only on beat BEATS_PER_PKT-1.
REQ-017 The serializer FSM SHALL have two states: IDLE and SEND. It moves IDLE->SEND when the FIFO is non-empty. It moves SEND->IDLE after the tlast handshake if the FIFO is then empty; otherwise it stays in SEND and begins the next packet at beat 0 with no bubble.
REQ-018 m_axis_tvalid, m_axis_tdata and m_axis_tlast SHALL be registered.
REQ-019 Once m_axis_tvalid is asserted, m_axis_tvalid, m_axis_tdata and m_axis_tlast SHALL be held stable until m_axis_tready is sampled high.
REQ-020 Latency from acceptance into an empty block to m_axis_tvalid high SHALL be exactly 1 cycle.
REQ-021 Sustained throughput SHALL be 1 beat per cycle while m_axis_tready is held high.
REQ-022 The head FIFO entry SHALL be freed at the tlast handshake.
REQ-023 On a full FIFO, a simultaneous tlast handshake and new input SHALL NOT be accepted that cycle; s_axis_tready SHALL rise the following cycle.
REQ-024 The beat index and FIFO pointers SHALL wrap modulo BEATS_PER_PKT and DEPTH respectively.
REQ-025 flush high SHALL, at the next edge, empty the FIFO, reset the beat index to 0, force the FSM to IDLE and deassert m_axis_tvalid, aborting any partial packet.
REQ-026 flush SHALL take priority over a simultaneous input or output handshake; the input packet in that cycle SHALL be dropped.
REQ-027 busy SHALL equal (level != 0) || (state == SEND).

Reset
REQ-028 While rstn is low, the outputs SHALL be: s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, level=0, pkt_cnt=0.
REQ-029 While rstn is low, the FSM SHALL be in IDLE and all pointers and the beat index SHALL be 0.
REQ-030 Reset asserted mid-packet SHALL discard all buffered data, with no partial beat emitted after release.

Configuration
REQ-031 With CGRA_TX_SER_CNT_EN defined, pkt_cnt SHALL increment by 1 on each tlast handshake and wrap from 2^32-1 to 0; flush SHALL NOT clear pkt_cnt.
REQ-032 Without CGRA_TX_SER_CNT_EN, pkt_cnt SHALL be tied to 0 and no counter flops SHALL be synthesized; the port SHALL still exist.

Structure
REQ-033 AXI_DATA_W, CGRA_PKT_W and BEATS_PER_PKT SHALL come from the shared SoC package, which sets the instance defaults.
REQ-034 The packet storage SHALL be a sub-module, cgra_tx_pkt_fifo: a synchronous FIFO, AXIS_W wide and DEPTH deep, with push, pop, flush, full, empty and count.

Verification
REQ-035 The bench SHALL send a single packet 0x...0003_...0002_...0001 (beats 1, 2, 3) with tready held at 1, and check: tvalid 1 cycle after acceptance, beats 1, 2, 3 in order, tlast on beat 3 only, pkt_cnt=1.
REQ-036 The bench SHALL send 4 back-to-back packets with tready=1, and check: 12 consecutive beats with no bubble, and tready dropping only when level=2.
REQ-037 The bench SHALL hold tready=0 for 10 cycles mid-beat 1, and check that data, tvalid and tlast remain stable and that beat 2 follows the release.
REQ-038 The bench SHALL assert flush after beat 0 of packet A with packet B queued, and check: tvalid=0 next cycle, level=0, and that the next packet C starts at beat 0.
REQ-039 The bench SHALL assert rstn low during beat 1, and check the reset values and that no stray beat appears after release.
REQ-040 With CGRA_TX_SER_CNT_EN, the bench SHALL preload pkt_cnt to 0xFFFF_FFFF via force and send one packet, and check that pkt_cnt wraps to 0.
